enxague: RTL and testbench

- Rinse stage of the washing-machine datapath; sits directly upstream of the spin stage.
- Runs NUM_ENXAGUES rinse cycles. Each cycle is fill -> agitate -> drain.
- When done, holds inicia_centrifugacao high, which drives the spin stage's level-sensitive start input.
- Fill and drain phases are watchdog-timed; a stuck water-level sensor sends the block to an error state.

---
 rtl/enxague.sv | 166 ++++++++++++++++
 tb/tb_enxague.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/enxague.sv
// Rinse stage: NUM_ENXAGUES x (fill -> agitate -> drain), then holds the spin-stage start level.
// Optional softener dosing on the last fill is enabled by defining ENXAGUE_AMACIANTE_EN.
module enxague #(
   parameter int unsigned NUM_ENXAGUES       = 2,
   parameter int unsigned TEMPO_AGITACAO     = 8,
   parameter int unsigned TIMEOUT_ENCHIMENTO = 16,
   parameter int unsigned TIMEOUT_DRENO      = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       nivel_cheio,
   input  logic       nivel_vazio,
   output logic       valvula_entrada,
   output logic       valvula_amaciante,
   output logic       motor_agitacao,
   output logic       bomba_dreno,
   output logic       enxague_ativo,
   output logic       inicia_centrifugacao,
   output logic       erro,
   output logic [2:0] estado,
   output logic [3:0] ciclo_atual
);

   localparam int unsigned TIMER_W = 8;
   localparam int unsigned CICLO_W = 4;

   localparam logic [TIMER_W-1:0] L_FIM_ENCH = TIMER_W'(TIMEOUT_ENCHIMENTO - 1);
   localparam logic [TIMER_W-1:0] L_FIM_AGIT = TIMER_W'(TEMPO_AGITACAO - 1);
   localparam logic [TIMER_W-1:0] L_FIM_DREN = TIMER_W'(TIMEOUT_DRENO - 1);
   localparam logic [CICLO_W-1:0] L_ULTIMO   = CICLO_W'(NUM_ENXAGUES - 1);

   typedef enum logic [2:0] {
      OCIOSO    = 3'd0,
      ENCHENDO  = 3'd1,
      AGITANDO  = 3'd2,
      DRENANDO  = 3'd3,
      CONCLUIDO = 3'd4,
      ERRO      = 3'd5
   } state_t;

   state_t               r_state;
   logic [TIMER_W-1:0]   r_timer;
   logic [CICLO_W-1:0]   r_ciclo;
   logic                 r_valvula_entrada;
   logic                 r_valvula_amaciante;
   logic                 r_motor_agitacao;
   logic                 r_bomba_dreno;
   logic                 r_enxague_ativo;
   logic                 r_inicia_centrifugacao;
   logic                 r_erro;

   state_t               w_state_nxt;
   logic [TIMER_W-1:0]   w_timer_nxt;
   logic [CICLO_W-1:0]   w_ciclo_nxt;
   logic                 w_amaciante_nxt;

   // Next-state logic; abort (start low) outranks every phase rule
   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_ciclo_nxt = r_ciclo;
      if ((r_state != OCIOSO) && !start) begin
         w_state_nxt = OCIOSO;
         w_timer_nxt = '0;
         w_ciclo_nxt = '0;
      end else begin
         case (r_state)
            OCIOSO: begin
               if (start) begin
                  w_state_nxt = ENCHENDO;
                  w_timer_nxt = '0;
                  w_ciclo_nxt = '0;
               end
            end
            ENCHENDO: begin
               if (nivel_cheio) begin
                  w_state_nxt = AGITANDO;
                  w_timer_nxt = '0;
               end else if (r_timer == L_FIM_ENCH) begin
                  w_state_nxt = ERRO;
                  w_timer_nxt = '0;
               end else begin
                  w_timer_nxt = r_timer + TIMER_W'(1);
               end
            end
            AGITANDO: begin
               if (r_timer == L_FIM_AGIT) begin
                  w_state_nxt = DRENANDO;
                  w_timer_nxt = '0;
               end else begin
                  w_timer_nxt = r_timer + TIMER_W'(1);
               end
            end
            DRENANDO: begin
               if (nivel_vazio) begin
                  w_timer_nxt = '0;
                  if (r_ciclo < L_ULTIMO) begin
                     w_state_nxt = ENCHENDO;
                     w_ciclo_nxt = r_ciclo + CICLO_W'(1);
                  end else begin
                     w_state_nxt = CONCLUIDO;
                  end
               end else if (r_timer == L_FIM_DREN) begin
                  w_state_nxt = ERRO;
                  w_timer_nxt = '0;
               end else begin
                  w_timer_nxt = r_timer + TIMER_W'(1);
               end
            end
            CONCLUIDO: w_state_nxt = CONCLUIDO;
            ERRO:      w_state_nxt = ERRO;
            default: begin
               w_state_nxt = OCIOSO;
               w_timer_nxt = '0;
               w_ciclo_nxt = '0;
            end
         endcase
      end
   end

`ifdef ENXAGUE_AMACIANTE_EN
   assign w_amaciante_nxt = (w_state_nxt == ENCHENDO) && (w_ciclo_nxt == L_ULTIMO);
`else
   assign w_amaciante_nxt = 1'b0;
`endif

   // Outputs are registered from the next state so they track the state register exactly
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state                <= OCIOSO;
         r_timer                <= '0;
         r_ciclo                <= '0;
         r_valvula_entrada      <= 1'b0;
         r_valvula_amaciante    <= 1'b0;
         r_motor_agitacao       <= 1'b0;
         r_bomba_dreno          <= 1'b0;
         r_enxague_ativo        <= 1'b0;
         r_inicia_centrifugacao <= 1'b0;
         r_erro                 <= 1'b0;
      end else begin
         r_state                <= w_state_nxt;
         r_timer                <= w_timer_nxt;
         r_ciclo                <= w_ciclo_nxt;
         r_valvula_entrada      <= (w_state_nxt == ENCHENDO);
         r_valvula_amaciante    <= w_amaciante_nxt;
         r_motor_agitacao       <= (w_state_nxt == AGITANDO);
         r_bomba_dreno          <= (w_state_nxt == DRENANDO);
         r_enxague_ativo        <= (w_state_nxt == ENCHENDO) || (w_state_nxt == AGITANDO) ||
                                   (w_state_nxt == DRENANDO);
         r_inicia_centrifugacao <= (w_state_nxt == CONCLUIDO);
         r_erro                 <= (w_state_nxt == ERRO);
      end
   end

   assign valvula_entrada      = r_valvula_entrada;
   assign valvula_amaciante    = r_valvula_amaciante;
   assign motor_agitacao       = r_motor_agitacao;
   assign bomba_dreno          = r_bomba_dreno;
   assign enxague_ativo        = r_enxague_ativo;
   assign inicia_centrifugacao = r_inicia_centrifugacao;
   assign erro                 = r_erro;
   assign estado               = r_state;
   assign ciclo_atual          = r_ciclo;

endmodule

// File: tb/tb_enxague.sv
// Testbench for enxague: directed scenarios plus random stimulus against a phase/elapsed-time model.
module tb_enxague;

   localparam int N_ENX = 2;
   localparam int T_AG  = 8;
   localparam int T_EN  = 16;
   localparam int T_DR  = 16;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       nivel_cheio = 1'b0;
   logic       nivel_vazio = 1'b0;
   logic       valvula_entrada, valvula_amaciante, motor_agitacao, bomba_dreno;
   logic       enxague_ativo, inicia_centrifugacao, erro;
   logic [2:0] estado;
   logic [3:0] ciclo_atual;

   enxague u_dut (
      .clock(clock), .reset(reset), .start(start),
      .nivel_cheio(nivel_cheio), .nivel_vazio(nivel_vazio),
      .valvula_entrada(valvula_entrada), .valvula_amaciante(valvula_amaciante),
      .motor_agitacao(motor_agitacao), .bomba_dreno(bomba_dreno),
      .enxague_ativo(enxague_ativo), .inicia_centrifugacao(inicia_centrifugacao),
      .erro(erro), .estado(estado), .ciclo_atual(ciclo_atual)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: phase, cycles already spent in phase, rinse index
   int m_ph  = 0;
   int m_n   = 0;
   int m_cyc = 0;

   // Sensor plant and pulse accounting
   int sens_mode = 0;   // 0: level rises after k cycles of actuation, 1: both stuck high, 2: random
   int fill_k = 0;
   int drain_k = 0;
   int run_f = 0, run_d = 0, run_m = 0;
   int tot_v = 0, tot_a = 0, tot_m = 0, tot_p = 0;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      if (reset) begin
         m_ph = 0; m_n = 0; m_cyc = 0;
      end else if (m_ph != 0 && !start) begin
         m_ph = 0; m_n = 0; m_cyc = 0;
      end else begin
         case (m_ph)
            0: if (start) begin m_ph = 1; m_n = 0; m_cyc = 0; end
            1: begin
               m_n++;
               if (nivel_cheio) begin m_ph = 2; m_n = 0; end
               else if (m_n == T_EN) begin m_ph = 5; m_n = 0; end
            end
            2: begin
               m_n++;
               if (m_n == T_AG) begin m_ph = 3; m_n = 0; end
            end
            3: begin
               m_n++;
               if (nivel_vazio) begin
                  m_n = 0;
                  if (m_cyc + 1 < N_ENX) begin m_ph = 1; m_cyc++; end
                  else m_ph = 4;
               end else if (m_n == T_DR) begin m_ph = 5; m_n = 0; end
            end
            default: ;
         endcase
      end
   endtask

   function automatic logic [15:0] exp_vec();
      logic amac;
`ifdef ENXAGUE_AMACIANTE_EN
      amac = (m_ph == 1) && (m_cyc == N_ENX - 1);
`else
      amac = 1'b0;
`endif
      return {2'b00, (m_ph == 1), amac, (m_ph == 2), (m_ph == 3),
              (m_ph >= 1 && m_ph <= 3), (m_ph == 4), (m_ph == 5),
              3'(m_ph), 4'(m_cyc)};
   endfunction

   function automatic logic [15:0] dut_vec();
      return {2'b00, valvula_entrada, valvula_amaciante, motor_agitacao, bomba_dreno,
              enxague_ativo, inicia_centrifugacao, erro, estado, ciclo_atual};
   endfunction

   task automatic tick();
      @(posedge clock);
      model_step();
      #1;
      chk("model", dut_vec(), exp_vec());
      run_f = valvula_entrada ? run_f + 1 : 0;
      run_d = bomba_dreno     ? run_d + 1 : 0;
      run_m = motor_agitacao  ? run_m + 1 : 0;
      if (valvula_entrada)   tot_v++;
      if (valvula_amaciante) tot_a++;
      if (motor_agitacao)    tot_m++;
      if (bomba_dreno)       tot_p++;
   endtask

   task automatic drive_sensors();
      case (sens_mode)
         0: begin
            nivel_cheio = (fill_k != 0) && (run_f >= fill_k);
            nivel_vazio = (drain_k != 0) && (run_d >= drain_k);
         end
         1: begin nivel_cheio = 1'b1; nivel_vazio = 1'b1; end
         default: begin
            nivel_cheio = ($urandom % 4) == 0;
            nivel_vazio = ($urandom % 4) == 0;
         end
      endcase
   endtask

   task automatic cyc();
      tick();
      drive_sensors();
   endtask

   task automatic go_idle_and_start();
      start = 1'b0;
      cyc();
      cyc();
      tot_v = 0; tot_a = 0; tot_m = 0; tot_p = 0;
      start = 1'b1;
   endtask

   initial begin
      // Reset
      reset = 1'b1;
      cyc();
      cyc();
      chk("reset_outs", dut_vec(), 16'h0000);
      reset = 1'b0;

      // Nominal run: full after 3 fill cycles, empty after 2 drain cycles
      sens_mode = 0; fill_k = 3; drain_k = 2;
      go_idle_and_start();
      cyc();
      chk("nom_valve_rise", 16'(valvula_entrada), 16'd1);
      for (int i = 0; i < 200 && estado != 3'd4; i++) cyc();
      chk("nom_done_state", 16'(estado), 16'd4);
      chk("nom_last_ciclo", 16'(ciclo_atual), 16'd1);
      for (int i = 0; i < 5; i++) cyc();
      chk("nom_inicia_held", 16'(inicia_centrifugacao), 16'd1);
      chk("nom_valve_total", 16'(tot_v), 16'd6);
      chk("nom_motor_total", 16'(tot_m), 16'd16);
      chk("nom_pump_total", 16'(tot_p), 16'd4);
`ifdef ENXAGUE_AMACIANTE_EN
      chk("nom_amac_total", 16'(tot_a), 16'd3);
`else
      chk("nom_amac_total", 16'(tot_a), 16'd0);
`endif
      start = 1'b0;
      cyc();
      chk("nom_inicia_drop", 16'(inicia_centrifugacao), 16'd0);

      // Fill timeout with stuck sensor
      fill_k = 0; drain_k = 0;
      go_idle_and_start();
      for (int i = 0; i < 22; i++) cyc();
      chk("to_valve_total", 16'(tot_v), 16'd16);
      chk("to_erro", 16'(erro), 16'd1);
      chk("to_estado", 16'(estado), 16'd5);
      chk("to_actuators", 16'({valvula_entrada, motor_agitacao, bomba_dreno}), 16'd0);
      start = 1'b0;
      cyc();
      chk("to_clear", 16'({erro, estado}), 16'd0);

      // Abort on agitation cycle 4, then restart
      fill_k = 1; drain_k = 2;
      go_idle_and_start();
      for (int i = 0; i < 40 && run_m != 4; i++) cyc();
      chk("ab_motor_run", 16'(run_m), 16'd4);
      start = 1'b0;
      cyc();
      chk("ab_stop", 16'({motor_agitacao, estado}), 16'd0);
      start = 1'b1;
      cyc();
      chk("ab_restart", 16'({estado, ciclo_atual}), 16'({3'd1, 4'd0}));

      // Full on the last allowed fill cycle wins over the timeout
      fill_k = 16; drain_k = 2;
      go_idle_and_start();
      for (int i = 0; i < 40 && !motor_agitacao && !erro; i++) cyc();
      chk("pr_fill_wins", 16'(estado), 16'd2);
      chk("pr_valve_total", 16'(tot_v), 16'd16);

      // Reset together with start while draining
      fill_k = 1; drain_k = 0;
      go_idle_and_start();
      for (int i = 0; i < 40 && !bomba_dreno; i++) cyc();
      chk("rd_in_drain", 16'(estado), 16'd3);
      reset = 1'b1;
      cyc();
      chk("rd_reset", dut_vec(), 16'h0000);
      reset = 1'b0;

      // Sensors permanently asserted
      sens_mode = 1;
      go_idle_and_start();
      drive_sensors();
      for (int i = 0; i < 60 && estado != 3'd4; i++) cyc();
      chk("sa_done", 16'(estado), 16'd4);
      chk("sa_valve_total", 16'(tot_v), 16'd2);
      chk("sa_motor_total", 16'(tot_m), 16'd16);
      chk("sa_pump_total", 16'(tot_p), 16'd2);

      // Random stimulus
      sens_mode = 2;
      for (int i = 0; i < 3000; i++) begin
         start = ($urandom % 40) != 0;
         reset = ($urandom % 300) == 0;
         cyc();
      end
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
